// File: rtl/decode_stage.sv
// Decode stage: buffers fetched instructions and slices them into op fields; DECODE_SKID_EN selects a 2-deep skid buffer.
// Latency: an instruction accepted at edge N is presented on the op outputs after edge N; flush clears the buffer at its edge.
// Backpressure: deque_o drops when the buffer is full; without DECODE_SKID_EN it follows op_ready_i combinationally.
module decode_stage #(
    parameter int I_WIDTH = 12,
    parameter int A_WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset_n_i,
    input  logic [I_WIDTH-1:0] instruction_data_i,
    input  logic [A_WIDTH-1:0] instruction_addr_i,
    input  logic               instruction_ready_i,
    output logic               deque_o,
    output logic               restart_o,
    output logic [A_WIDTH-1:0] restart_addr_o,
    input  logic               flush_i,
    input  logic [A_WIDTH-1:0] flush_addr_i,
    input  logic               op_ready_i,
    output logic               op_valid_o,
    output logic [3:0]         opcode_o,
    output logic [1:0]         ra_o,
    output logic [1:0]         rb_o,
    output logic [7:0]         imm_o,
    output logic [A_WIDTH-1:0] op_addr_o
);

`ifdef DECODE_SKID_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    typedef enum logic {S_RESTART, S_RUN} state_t;

    typedef struct packed {
        logic [A_WIDTH-1:0] addr;
        logic [I_WIDTH-1:0] data;
    } entry_t;

    state_t             state_q;
    logic               restart_q;
    logic [A_WIDTH-1:0] restart_addr_q;

    entry_t             buf_q [DEPTH];
    entry_t             buf_d [DEPTH];
    logic [1:0]         count_q;
    logic [1:0]         count_d;
    logic [1:0]         wr_idx;
    logic               enq;
    logic               deq;
    entry_t             head;

    // deque_o is forced low while reset is held, independent of the state register.
    always_comb begin
        deque_o = 1'b0;
        if (reset_n_i && state_q == S_RUN && !flush_i) begin
`ifdef DECODE_SKID_EN
            deque_o = (count_q < 2'd2);
`else
            deque_o = (count_q == 2'd0) || op_ready_i;
`endif
        end
    end

    assign op_valid_o = (count_q != 2'd0);
    assign enq        = instruction_ready_i && deque_o;
    assign deq        = op_valid_o && op_ready_i;
    assign wr_idx     = count_q - (deq ? 2'd1 : 2'd0);

    always_comb begin
        buf_d   = buf_q;
        count_d = count_q;
        if (flush_i) begin
            count_d = 2'd0;
        end else begin
            if (deq) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    buf_d[i] = buf_q[i + 1];
                end
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (enq && wr_idx == 2'(i)) begin
                    buf_d[i] = '{addr: instruction_addr_i, data: instruction_data_i};
                end
            end
            count_d = count_q + (enq ? 2'd1 : 2'd0) - (deq ? 2'd1 : 2'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n_i) begin
            count_q <= 2'd0;
        end else begin
            count_q <= count_d;
        end
    end

    // Payload storage needs no reset: occupancy alone qualifies it.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    always_ff @(posedge clk) begin
        if (!reset_n_i) begin
            state_q        <= S_RESTART;
            restart_q      <= 1'b1;
            restart_addr_q <= '0;
        end else begin
            case (state_q)
                S_RESTART: begin
                    if (flush_i) begin
                        restart_addr_q <= flush_addr_i;
                    end else begin
                        state_q   <= S_RUN;
                        restart_q <= 1'b0;
                    end
                end
                default: begin
                    if (flush_i) begin
                        state_q        <= S_RESTART;
                        restart_q      <= 1'b1;
                        restart_addr_q <= flush_addr_i;
                    end
                end
            endcase
        end
    end

    assign restart_o      = restart_q;
    assign restart_addr_o = restart_addr_q;

    assign head      = buf_q[0];
    assign opcode_o  = head.data[11:8];
    assign ra_o      = head.data[7:6];
    assign rb_o      = head.data[5:4];
    assign imm_o     = head.data[7:0];
    assign op_addr_o = head.addr;

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter I_WIDTH, default 12, instruction width.
REQ-002 SHALL have parameter A_WIDTH, default 8, instruction address width.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n_i  input  1  synchronous, active-low reset.
REQ-005 SHALL have port instruction_data_i  input  I_WIDTH  instruction from fetch.
REQ-006 SHALL have port instruction_addr_i  input  A_WIDTH  address of instruction_data_i.
REQ-007 SHALL have port instruction_ready_i  input  1  fetch holds a valid instruction.
REQ-008 SHALL have port deque_o  output  1  decode consumes the fetch head this cycle.
REQ-009 SHALL have port restart_o  output  1  fetch restart request.
REQ-010 SHALL have port restart_addr_o  output  A_WIDTH  fetch restart address.
REQ-011 SHALL have port flush_i  input  1  exec redirect, e.g. taken branch.
REQ-012 SHALL have port flush_addr_i  input  A_WIDTH  redirect target.
REQ-013 SHALL have port op_ready_i  input  1  exec can accept an op.
REQ-014 SHALL have port op_valid_o  output  1  decoded op present.
REQ-015 SHALL have port opcode_o  output  4  instruction[11:8].
REQ-016 SHALL have port ra_o / rb_o  output  2 each  instruction[7:6] / [5:4].
REQ-017 SHALL have port imm_o  output  8  instruction[7:0].
REQ-018 SHALL have port op_addr_o  output  A_WIDTH  address of the op.

Function
REQ-019 SHALL implement a two-state FSM: RESTART and RUN.
REQ-020 In RESTART: restart_o=1; deque_o=0; next state RUN unless flush_i=1, which keeps RESTART and reloads restart_addr_o.
REQ-021 In RUN: restart_o=0; flush_i=1 -> next state RESTART, restart_addr_o<=flush_addr_i, buffer cleared at the same edge.
REQ-022 restart_o and restart_addr_o SHALL be registered.
REQ-023 Fetch transfer = instruction_ready_i & deque_o; exec transfer = op_valid_o & op_ready_i.
REQ-024 deque_o SHALL be 0 whenever state≠RUN or flush_i=1.
REQ-025 Buffer SHALL be FIFO-ordered. An instruction accepted at edge N SHALL appear on the outputs after edge N (1-cycle latency).
REQ-026 op_valid_o SHALL be 1 exactly when the buffer is non-empty.
REQ-027 opcode_o/ra_o/rb_o/imm_o/op_addr_o SHALL be pure bit-slices of the buffer head; they are don't-care when op_valid_o=0.
REQ-028 Simultaneous fetch and exec transfers SHALL keep occupancy unchanged and preserve order.
REQ-029 flush_i SHALL override every same-cycle transfer: no instruction is enqueued, and exec transfer state is discarded.
REQ-030 Instruction and address widths are carried unmodified; no arithmetic on addresses.

Reset
REQ-031 reset_n_i=0 at an edge -> state RESTART, restart_o=1, restart_addr_o=0, buffer empty (op_valid_o=0); deque_o=0 while in reset.
REQ-032 Reset asserted mid-operation SHALL discard all buffered ops and any pending flush.
REQ-033 First edge with reset_n_i=1 -> state RUN, restart_o=0.

Configuration
REQ-034 Macro DECODE_SKID_EN defined: buffer depth 2; deque_o = RUN & !flush_i & (count<2), with no combinational path from op_ready_i.
REQ-035 DECODE_SKID_EN undefined: depth 1; deque_o = RUN & !flush_i & (count==0 | op_ready_i).

Verification
REQ-036 Reset low for 2 cycles, then released -> restart_o=1 and restart_addr_o=0x00 during reset; restart_o=0 one cycle after release.
REQ-037 Fetch offers 0x123@0x00 with op_ready_i=1 -> deque_o=1; next cycle op_valid_o=1, opcode_o=0x1, ra_o=0, rb_o=2, imm_o=0x23, op_addr_o=0x00.
REQ-038 op_ready_i=0 with fetch continuously ready -> without skid, deque_o falls after 1 accept; with DECODE_SKID_EN, after 2 accepts; order is preserved on release.
REQ-039 flush_i=1 with flush_addr_i=0x40 while buffer full -> next cycle op_valid_o=0, restart_o=1, restart_addr_o=0x40, deque_o=0; RUN the cycle after.
REQ-040 flush_i held 2 cycles with addresses 0x10 then 0x20 -> restart_o=1 for 2 cycles, final restart_addr_o=0x20.
REQ-041 Stream 0x001..0x005 at op_ready_i=1 -> exec sees all 5 in order, one per cycle in steady state, with no duplicates or drops.
